mem_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch path (IF port) and the data-access path (DM port: load/store).
- Sits between the multi-cycle core (fetch and memaccess stages) and the memory.
- Arbitrates with data-priority plus an anti-starvation counter.
- Tolerates variable memory latency through a ready handshake, with timeout and error reporting.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and data access
//
// Purpose: gives the one unified memory port to either the fetch path (IF) or
// the load/store path (DM). DM normally wins when both ask at once. An IF
// starvation counter lets IF win after STARVE_LIMIT DM grants taken while IF
// was waiting. The memory may take several cycles, signalled by i_mem_ready.
// A transfer that waits TIMEOUT cycles is aborted and flagged on o_bus_error.
//
// Ports:
//   clock, reset           system clock; asynchronous active-high reset
//   i_if_req, i_if_addr    fetch request (level) and address
//   o_if_rdata, o_if_ack   fetched word and one-cycle completion pulse
//   i_dm_req, i_dm_we      data request (level); 1 = store, 0 = load
//   i_dm_addr, i_dm_wdata  data address and store data
//   o_dm_rdata, o_dm_ack   load data and one-cycle completion pulse
//   o_mem_en, o_mem_we     memory strobe and write enable
//   o_mem_addr, o_mem_wdata memory address and write data
//   i_mem_rdata, i_mem_ready memory read data and completion
//   o_owner                00 none, 01 IF, 10 DM
//   o_bus_error            pulses together with the ack of an aborted transfer
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    output logic                  o_if_ack,
    input  logic                  i_dm_req,
    input  logic                  i_dm_we,
    input  logic [ADDR_WIDTH-1:0] i_dm_addr,
    input  logic [DATA_WIDTH-1:0] i_dm_wdata,
    output logic [DATA_WIDTH-1:0] o_dm_rdata,
    output logic                  o_dm_ack,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ready,
    output logic [1:0]            o_owner,
    output logic                  o_bus_error
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_DM   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                r_state;
    logic [SW-1:0]         r_starve_cnt;
    logic [TW-1:0]         r_timeout_cnt;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic                  r_if_ack;
    logic                  r_dm_ack;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [1:0]            r_owner;
    logic                  r_bus_error;

    logic w_if_wins;
    logic w_starved;
    logic w_done;
    logic w_abort;

    // IF wins when alone, or when it has been passed over STARVE_LIMIT times.
    assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
    assign w_if_wins = i_if_req && (!i_dm_req || w_starved);
    // A ready in the last allowed cycle still counts as a normal completion.
    assign w_abort   = !i_mem_ready && (r_timeout_cnt == TW'(TIMEOUT - 1));
    assign w_done    = i_mem_ready || w_abort;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_starve_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_if_rdata    <= '0;
            r_dm_rdata    <= '0;
            r_if_ack      <= 1'b0;
            r_dm_ack      <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_owner       <= OWN_NONE;
            r_bus_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_if_req || i_dm_req) begin
                        r_state       <= S_BUSY;
                        r_mem_en      <= 1'b1;
                        r_timeout_cnt <= '0;
                        if (w_if_wins) begin
                            r_owner      <= OWN_IF;
                            r_mem_we     <= 1'b0;
                            r_mem_addr   <= i_if_addr;
                            r_mem_wdata  <= '0;
                            r_starve_cnt <= '0;
                        end else begin
                            r_owner     <= OWN_DM;
                            r_mem_we    <= i_dm_we;
                            r_mem_addr  <= i_dm_addr;
                            r_mem_wdata <= i_dm_wdata;
                            if (i_if_req && !w_starved) begin
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    if (w_done) begin
                        // Stores never touch dm_rdata; aborted reads return zero.
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= w_abort ? '0 : i_mem_rdata;
                            r_if_ack   <= 1'b1;
                        end else begin
                            if (!r_mem_we) begin
                                r_dm_rdata <= w_abort ? '0 : i_mem_rdata;
                            end
                            r_dm_ack <= 1'b1;
                        end
                        r_bus_error <= w_abort;
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_owner     <= OWN_NONE;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_if_ack      <= 1'b0;
                    r_dm_ack      <= 1'b0;
                    r_bus_error   <= 1'b0;
                    r_timeout_cnt <= '0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_if_ack    = r_if_ack;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_ack    = r_dm_ack;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_owner     = r_owner;
    assign o_bus_error = r_bus_error;

endmodule
